// File: rtl/pcie_hcmd_sq_req_pkg.sv
// Shared definitions for the SQ fetch request path: FSM encoding, fetch length,
// default PCIe tag base and the tag-table entry layout.
package pcie_hcmd_sq_req_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_GNT  = 4'b0010,
    S_TBL  = 4'b0100,
    S_REQ  = 4'b1000
  } sq_req_state_e;

  // One 64-byte submission queue entry, expressed in DWs.
  localparam logic [9:0] HCMD_DW_LEN  = 10'd16;
  localparam logic [7:0] DEF_TAG_BASE = 8'h10;

  // Tag-table entry is {qid, slot}; qid occupies the upper bits.
  localparam int TBL_QID_W = 4;

endpackage

// File: rtl/pcie_hcmd_tag_pool.sv
// PCIe read-tag pool: busy bitmap with lowest-free allocation, range-checked
// retire and a registered count of outstanding tags.
module pcie_hcmd_tag_pool #(
  parameter int         C_NUM_TAGS = 4,
  parameter int         C_TAG_BITS = 2,
  parameter logic [7:0] C_TAG_BASE = 8'h10
) (
  input  logic                  pcie_user_clk,
  input  logic                  pcie_user_rst_n,
  input  logic                  alloc_en,
  output logic [C_TAG_BITS-1:0] alloc_idx,
  output logic                  any_free,
  input  logic                  free_en,
  input  logic [7:0]            free_tag,
  output logic [C_TAG_BITS:0]   outstanding
);

  logic [C_NUM_TAGS-1:0] busy;
  logic [C_NUM_TAGS-1:0] busy_nxt;
  logic [7:0]            free_off;
  logic                  free_hit;

  function automatic logic [C_TAG_BITS:0] popcount(input logic [C_NUM_TAGS-1:0] v);
    logic [C_TAG_BITS:0] cnt;
    cnt = '0;
    for (int i = 0; i < C_NUM_TAGS; i++) cnt = cnt + (C_TAG_BITS+1)'(v[i]);
    return cnt;
  endfunction

  assign any_free = ~&busy;

  always_comb begin
    alloc_idx = '0;
    for (int i = C_NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) alloc_idx = C_TAG_BITS'(i);
    end
  end

  // Tags below the base wrap to a large offset, so one compare covers both bounds.
  assign free_off = free_tag - C_TAG_BASE;
  assign free_hit = free_en && (free_off < 8'(C_NUM_TAGS)) && busy[free_off[C_TAG_BITS-1:0]];

  always_comb begin
    busy_nxt = busy;
    if (free_hit) busy_nxt[free_off[C_TAG_BITS-1:0]] = 1'b0;
    if (alloc_en) busy_nxt[alloc_idx] = 1'b1;
  end

  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      busy        <= '0;
      outstanding <= '0;
    end else begin
      busy        <= busy_nxt;
      outstanding <= popcount(busy_nxt);
    end
  end

endmodule

// File: rtl/pcie_hcmd_sq_req.sv
// SQ entry fetch requester: accepts an arbiter grant, allocates a slot and a
// read tag, records tag->{qid,slot}, then issues one 16-DW memory read.
module pcie_hcmd_sq_req
  import pcie_hcmd_sq_req_pkg::*;
#(
  parameter int         C_PCIE_ADDR_WIDTH = 48,
  parameter int         C_NUM_TAGS        = 4,
  parameter int         C_TAG_BITS        = 2,
  parameter logic [7:0] C_TAG_BASE        = DEF_TAG_BASE,
  parameter int         C_SLOT_BITS       = 7
) (
  input  logic                            pcie_user_clk,
  input  logic                            pcie_user_rst_n,
  input  logic                            arb_sq_rdy,
  input  logic [TBL_QID_W-1:0]            sq_qid,
  input  logic [C_PCIE_ADDR_WIDTH-1:2]    hcmd_pcie_addr,
  output logic                            sq_hcmd_ack,
  input  logic                            hcmd_slot_rdy,
  input  logic [C_SLOT_BITS-1:0]          hcmd_slot_tag,
  output logic                            hcmd_slot_alloc_en,
  output logic                            tag_tbl_wr_en,
  output logic [C_TAG_BITS-1:0]           tag_tbl_wr_addr,
  output logic [TBL_QID_W+C_SLOT_BITS-1:0] tag_tbl_wr_data,
  output logic                            tx_mrd_req,
  output logic [7:0]                      tx_mrd_tag,
  output logic [9:0]                      tx_mrd_len,
  output logic [C_PCIE_ADDR_WIDTH-1:2]    tx_mrd_addr,
  input  logic                            tx_mrd_req_ack,
  input  logic                            cpld_done,
  input  logic [7:0]                      cpld_done_tag,
  output logic [C_TAG_BITS:0]             tag_outstanding
);

  sq_req_state_e                  state;
  sq_req_state_e                  state_nxt;
  logic [TBL_QID_W-1:0]           qid_r;
  logic [C_PCIE_ADDR_WIDTH-1:2]   addr_r;
  logic [C_SLOT_BITS-1:0]         slot_r;
  logic [C_TAG_BITS-1:0]          tag_r;
  logic [C_TAG_BITS-1:0]          alloc_idx;
  logic                           any_free;

  pcie_hcmd_tag_pool #(
    .C_NUM_TAGS (C_NUM_TAGS),
    .C_TAG_BITS (C_TAG_BITS),
    .C_TAG_BASE (C_TAG_BASE)
  ) u_tag_pool (
    .pcie_user_clk   (pcie_user_clk),
    .pcie_user_rst_n (pcie_user_rst_n),
    .alloc_en        (state == S_GNT),
    .alloc_idx       (alloc_idx),
    .any_free        (any_free),
    .free_en         (cpld_done),
    .free_tag        (cpld_done_tag),
    .outstanding     (tag_outstanding)
  );

  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) state <= S_IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    sq_hcmd_ack        = 1'b0;
    hcmd_slot_alloc_en = 1'b0;
    tag_tbl_wr_en      = 1'b0;
    tx_mrd_req         = 1'b0;
    unique case (state)
      S_IDLE: if (arb_sq_rdy && hcmd_slot_rdy && any_free) state_nxt = S_GNT;
      S_GNT: begin
        sq_hcmd_ack        = 1'b1;
        hcmd_slot_alloc_en = 1'b1;
        state_nxt          = S_TBL;
      end
      S_TBL: begin
        tag_tbl_wr_en = 1'b1;
        state_nxt     = S_REQ;
      end
      S_REQ: begin
        tx_mrd_req = 1'b1;
        if (tx_mrd_req_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant fields are captured in the ack cycle, while the arbiter still holds them.
  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      qid_r  <= '0;
      addr_r <= '0;
      slot_r <= '0;
      tag_r  <= '0;
    end else if (state == S_GNT) begin
      qid_r  <= sq_qid;
      addr_r <= hcmd_pcie_addr;
      slot_r <= hcmd_slot_tag;
      tag_r  <= alloc_idx;
    end
  end

  assign tag_tbl_wr_addr = tag_r;
  assign tag_tbl_wr_data = {qid_r, slot_r};
  assign tx_mrd_tag      = C_TAG_BASE + 8'(tag_r);
  assign tx_mrd_len      = HCMD_DW_LEN;
  assign tx_mrd_addr     = addr_r;

endmodule

// File: tb/tb_pcie_hcmd_sq_req.sv
// Randomized scoreboard bench for pcie_hcmd_sq_req with a command-level
// reference model (one fetch in flight, set of busy tags, lowest free wins).
module tb_pcie_hcmd_sq_req;

  typedef struct packed {
    logic [3:0]  qid;
    logic [45:0] addr;
    logic [6:0]  slot;
  } cmd_t;

  logic        pcie_user_clk;
  logic        pcie_user_rst_n;
  logic        arb_sq_rdy;
  logic [3:0]  sq_qid;
  logic [45:0] hcmd_pcie_addr;
  logic        sq_hcmd_ack;
  logic        hcmd_slot_rdy;
  logic [6:0]  hcmd_slot_tag;
  logic        hcmd_slot_alloc_en;
  logic        tag_tbl_wr_en;
  logic [1:0]  tag_tbl_wr_addr;
  logic [10:0] tag_tbl_wr_data;
  logic        tx_mrd_req;
  logic [7:0]  tx_mrd_tag;
  logic [9:0]  tx_mrd_len;
  logic [45:0] tx_mrd_addr;
  logic        tx_mrd_req_ack;
  logic        cpld_done;
  logic [7:0]  cpld_done_tag;
  logic [2:0]  tag_outstanding;

  pcie_hcmd_sq_req dut (
    .pcie_user_clk      (pcie_user_clk),
    .pcie_user_rst_n    (pcie_user_rst_n),
    .arb_sq_rdy         (arb_sq_rdy),
    .sq_qid             (sq_qid),
    .hcmd_pcie_addr     (hcmd_pcie_addr),
    .sq_hcmd_ack        (sq_hcmd_ack),
    .hcmd_slot_rdy      (hcmd_slot_rdy),
    .hcmd_slot_tag      (hcmd_slot_tag),
    .hcmd_slot_alloc_en (hcmd_slot_alloc_en),
    .tag_tbl_wr_en      (tag_tbl_wr_en),
    .tag_tbl_wr_addr    (tag_tbl_wr_addr),
    .tag_tbl_wr_data    (tag_tbl_wr_data),
    .tx_mrd_req         (tx_mrd_req),
    .tx_mrd_tag         (tx_mrd_tag),
    .tx_mrd_len         (tx_mrd_len),
    .tx_mrd_addr        (tx_mrd_addr),
    .tx_mrd_req_ack     (tx_mrd_req_ack),
    .cpld_done          (cpld_done),
    .cpld_done_tag      (cpld_done_tag),
    .tag_outstanding    (tag_outstanding)
  );

  initial pcie_user_clk = 1'b0;
  always #5 pcie_user_clk = ~pcie_user_clk;

  int errors = 0;
  int checks = 0;

  // Stimulus knobs
  int   cmds_left = 0;
  int   arb_prob = 100, slot_prob = 100, cpld_prob = 0;
  int   tx_wmin = 0, tx_wmax = 0;
  bit   tx_ack_en = 1;
  bit   use_fixed = 0;
  bit   force_valid = 0;
  logic [7:0] force_tag = 8'h00;
  bit   presented = 0;
  bit   got_ack = 0;

  // Reference model state
  cmd_t       cmd_q[$];
  logic [7:0] issued_q[$];
  bit         busy_m[4];
  bit         inflight = 0;
  bit         gok = 0;
  cmd_t       cur;
  logic [1:0] cur_tag = 2'd0;
  int         cyc = 0, tbl_due = -1, req_from = 0, req_run = 0;
  int         n_acks = 0, last_req_cycles = 0;
  logic [7:0] last_tx_tag = 8'h00;
  logic [45:0] last_tx_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 4; i++) if (!busy_m[i]) return i;
    return -1;
  endfunction

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(busy_m[i]);
    return n;
  endfunction

  // Arbiter and slot allocator
  always begin
    cmd_t c;
    @(posedge pcie_user_clk); #1;
    if (got_ack) begin
      got_ack    = 0;
      presented  = 0;
      arb_sq_rdy = 1'b0;
    end
    if (!presented && cmds_left > 0 && $urandom_range(0, 99) < arb_prob) begin
      if (use_fixed) c = '{qid: 4'd3, addr: 46'h1000, slot: 7'd5};
      else c = '{qid: 4'($urandom), addr: 46'({$urandom, $urandom}), slot: 7'($urandom)};
      sq_qid         = c.qid;
      hcmd_pcie_addr = c.addr;
      hcmd_slot_tag  = c.slot;
      arb_sq_rdy     = 1'b1;
      cmd_q.push_back(c);
      presented = 1;
      cmds_left--;
    end
    hcmd_slot_rdy = ($urandom_range(0, 99) < slot_prob);
  end

  // TX path acceptance with programmable backpressure
  always begin
    int tx_cnt;
    tx_cnt = -1;
    forever begin
      @(posedge pcie_user_clk); #1;
      tx_mrd_req_ack = 1'b0;
      if (!tx_mrd_req) tx_cnt = -1;
      else if (tx_ack_en) begin
        if (tx_cnt < 0) tx_cnt = $urandom_range(tx_wmin, tx_wmax);
        if (tx_cnt == 0) begin
          tx_mrd_req_ack = 1'b1;
          tx_cnt = -1;
        end else tx_cnt--;
      end
    end
  end

  // Completion path: retires issued tags, plus stray/out-of-range tags
  always begin
    int i;
    @(posedge pcie_user_clk); #1;
    cpld_done     = 1'b0;
    cpld_done_tag = 8'h00;
    if (force_valid) begin
      cpld_done     = 1'b1;
      cpld_done_tag = force_tag;
      force_valid   = 0;
    end else if ($urandom_range(0, 99) < cpld_prob) begin
      cpld_done = 1'b1;
      if (issued_q.size() > 0 && $urandom_range(0, 9) < 7) begin
        i = $urandom_range(0, issued_q.size() - 1);
        cpld_done_tag = issued_q[i];
        issued_q.delete(i);
      end else cpld_done_tag = 8'($urandom);
    end
  end

  // Monitor / scoreboard
  always @(negedge pcie_user_clk) begin
    bit         exp_wr, exp_req, gok_nxt;
    logic [7:0] off;
    cyc++;
    if (!pcie_user_rst_n) begin
      for (int i = 0; i < 4; i++) busy_m[i] = 0;
      inflight = 0;
      gok      = 0;
      tbl_due  = -1;
      req_run  = 0;
      cmd_q.delete();
      issued_q.delete();
    end else begin
      if (sq_hcmd_ack) begin
        n_acks++;
        got_ack = 1;
      end
      if (gok) begin
        if (cmd_q.size() == 0) chk("cmd_queue_empty", 64'd0, 64'd1);
        else cur = cmd_q.pop_front();
        cur_tag  = 2'(lowest_free());
        tbl_due  = cyc + 1;
        req_from = cyc + 2;
      end
      chk("sq_hcmd_ack", 64'(sq_hcmd_ack), 64'(gok));
      chk("hcmd_slot_alloc_en", 64'(hcmd_slot_alloc_en), 64'(gok));
      exp_wr = (cyc == tbl_due);
      chk("tag_tbl_wr_en", 64'(tag_tbl_wr_en), 64'(exp_wr));
      if (exp_wr) begin
        chk("tag_tbl_wr_addr", 64'(tag_tbl_wr_addr), 64'(cur_tag));
        chk("tag_tbl_wr_data", 64'(tag_tbl_wr_data), 64'({cur.qid, cur.slot}));
      end
      exp_req = inflight && (cyc >= req_from);
      chk("tx_mrd_req", 64'(tx_mrd_req), 64'(exp_req));
      if (exp_req) begin
        chk("tx_mrd_tag", 64'(tx_mrd_tag), 64'(8'h10 + 8'(cur_tag)));
        chk("tx_mrd_addr", 64'(tx_mrd_addr), 64'(cur.addr));
        chk("tx_mrd_len", 64'(tx_mrd_len), 64'd16);
      end
      chk("tag_outstanding", 64'(tag_outstanding), 64'(busy_count()));
      req_run = tx_mrd_req ? req_run + 1 : 0;

      gok_nxt = !inflight && arb_sq_rdy && hcmd_slot_rdy && (lowest_free() >= 0);
      if (exp_req && tx_mrd_req_ack) begin
        inflight = 0;
        issued_q.push_back(8'h10 + 8'(cur_tag));
        last_tx_tag     = tx_mrd_tag;
        last_tx_addr    = tx_mrd_addr;
        last_req_cycles = req_run;
      end
      if (cpld_done) begin
        off = cpld_done_tag - 8'h10;
        if (off < 8'd4 && busy_m[off[1:0]]) busy_m[off[1:0]] = 0;
      end
      if (gok) busy_m[cur_tag] = 1;
      if (gok_nxt) inflight = 1;
      gok = gok_nxt;
    end
  end

  task automatic wait_quiet(input int maxc, input string what);
    int n;
    n = 0;
    while ((cmds_left > 0 || presented || inflight) && n < maxc) begin
      @(negedge pcie_user_clk); #1;
      n++;
    end
    if (n >= maxc) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles, still busy", what, maxc);
    end
    @(negedge pcie_user_clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n;
    pcie_user_rst_n = 1'b1;
    arb_sq_rdy = 1'b0; sq_qid = '0; hcmd_pcie_addr = '0;
    hcmd_slot_rdy = 1'b0; hcmd_slot_tag = '0;
    tx_mrd_req_ack = 1'b0; cpld_done = 1'b0; cpld_done_tag = '0;
    #2 pcie_user_rst_n = 1'b0;
    #1;
    chk("rst_sq_hcmd_ack", 64'(sq_hcmd_ack), 64'd0);
    chk("rst_slot_alloc_en", 64'(hcmd_slot_alloc_en), 64'd0);
    chk("rst_tag_tbl_wr_en", 64'(tag_tbl_wr_en), 64'd0);
    chk("rst_tx_mrd_req", 64'(tx_mrd_req), 64'd0);
    chk("rst_tag_outstanding", 64'(tag_outstanding), 64'd0);
    chk("rst_tx_mrd_len", 64'(tx_mrd_len), 64'd16);
    chk("rst_tx_mrd_addr", 64'(tx_mrd_addr), 64'd0);
    chk("rst_tag_tbl_wr_data", 64'(tag_tbl_wr_data), 64'd0);
    repeat (3) @(negedge pcie_user_clk);
    #2 pcie_user_rst_n = 1'b1;
    repeat (2) @(negedge pcie_user_clk);

    // Single fixed command
    use_fixed = 1; cmds_left = 1;
    wait_quiet(40, "single_cmd");
    use_fixed = 0;
    chk("single_tag", 64'(last_tx_tag), 64'h10);
    chk("single_addr", 64'(last_tx_addr), 64'h1000);
    chk("single_outstanding", 64'(tag_outstanding), 64'd1);

    // Tag exhaustion: three more fit, the next one must stall
    cmds_left = 4;
    repeat (30) @(negedge pcie_user_clk);
    #1;
    chk("exhaust_acks", 64'(n_acks), 64'd4);
    chk("exhaust_outstanding", 64'(tag_outstanding), 64'd4);
    force_tag = 8'h11; force_valid = 1;
    n = 0;
    while (n_acks < 5 && n < 20) begin @(negedge pcie_user_clk); #1; n++; end
    chk("exhaust_reacked", 64'(n_acks), 64'd5);
    wait_quiet(40, "exhaust_drain");
    chk("exhaust_reuse_tag", 64'(last_tx_tag), 64'h11);

    // Free everything, then a 7-cycle TX backpressure
    cpld_prob = 100;
    repeat (60) @(negedge pcie_user_clk);
    cpld_prob = 0;
    repeat (3) @(negedge pcie_user_clk);
    #1;
    chk("drain_outstanding", 64'(tag_outstanding), 64'd0);
    tx_wmin = 7; tx_wmax = 7; cmds_left = 1;
    wait_quiet(60, "backpressure");
    chk("backpressure_req_cycles", 64'(last_req_cycles), 64'd8);
    tx_wmin = 0; tx_wmax = 0;

    // Slot stall
    slot_prob = 0;
    n0 = n_acks;
    cmds_left = 1;
    repeat (10) @(negedge pcie_user_clk);
    #1;
    chk("slot_stall_no_ack", 64'(n_acks), 64'(n0));
    slot_prob = 100;
    wait_quiet(40, "slot_release");
    chk("slot_release_ack", 64'(n_acks), 64'(n0 + 1));

    // Randomized traffic with retires, stray tags and backpressure
    arb_prob = 70; slot_prob = 80; cpld_prob = 40;
    tx_wmin = 0; tx_wmax = 3;
    cmds_left = 300;
    wait_quiet(20000, "random_traffic");

    // Reset while a request is waiting in S_REQ
    cpld_prob = 0; arb_prob = 100; slot_prob = 100; tx_wmax = 0;
    tx_ack_en = 0;
    cmds_left = 1;
    n = 0;
    while (!tx_mrd_req && n < 50) begin @(negedge pcie_user_clk); n++; end
    chk("reset_test_req_seen", 64'(tx_mrd_req), 64'd1);
    #2 pcie_user_rst_n = 1'b0;
    #1;
    chk("reset_drops_req", 64'(tx_mrd_req), 64'd0);
    chk("reset_clears_outstanding", 64'(tag_outstanding), 64'd0);
    repeat (3) @(negedge pcie_user_clk);
    #2 pcie_user_rst_n = 1'b1;
    tx_ack_en = 1;
    repeat (2) @(negedge pcie_user_clk);
    cmds_left = 1;
    wait_quiet(40, "post_reset_cmd");
    chk("post_reset_tag", 64'(last_tx_tag), 64'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
